// File: rtl/tcdm_xbar_node.sv
// tcdm_xbar_node: full crossbar node with per-port round-robin trees and per-master response tracking
module tcdm_xbar_node #(
    parameter int NumIn         = 4,
    parameter int NumOut        = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter bit WriteRespOn   = 1,
    parameter int MemLatency    = 1,
    parameter bit NodeType      = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumIn-1:0]                  req_i,
    input  logic [NumIn*$clog2(NumOut)-1:0]   add_i,
    input  logic [NumIn-1:0]                  wen_i,
    input  logic [NumIn*ReqDataWidth-1:0]     wdata_i,
    output logic [NumIn-1:0]                  gnt_o,
    output logic [NumIn-1:0]                  vld_o,
    output logic [NumIn*RespDataWidth-1:0]    rdata_o,
    input  logic [NumOut-1:0]                 gnt_i,
    output logic [NumOut-1:0]                 req_o,
    output logic [NumOut*ReqDataWidth-1:0]    wdata_o,
    input  logic [NumOut*RespDataWidth-1:0]   rdata_i
);
    localparam int LogIn  = $clog2(NumIn);
    localparam int LogOut = $clog2(NumOut);

    // Binary tree reduced in place: node n of level b+1 is built from nodes 2n, 2n+1 of level b,
    // the odd child being the one whose index bit b is set.
    function automatic logic [LogIn-1:0] arb_win(input logic [NumIn-1:0] r, input logic [LogIn-1:0] rr);
        logic [NumIn-1:0] nreq;
        logic [LogIn-1:0] nidx [NumIn];
        logic             pick_hi;
        nreq = r;
        for (int i = 0; i < NumIn; i++) nidx[i] = LogIn'(i);
        for (int b = 0; b < LogIn; b++) begin
            for (int n = 0; n < (NumIn >> (b + 1)); n++) begin
                pick_hi = nreq[2*n+1] && (!nreq[2*n] || rr[b]);
                nidx[n] = pick_hi ? nidx[2*n+1] : nidx[2*n];
                nreq[n] = nreq[2*n] | nreq[2*n+1];
            end
        end
        return nidx[0];
    endfunction

    logic [NumIn-1:0]  port_req [NumOut];
    logic [NumIn-1:0]  port_gnt [NumOut];
    logic [LogIn-1:0]  win      [NumOut];
    logic [LogIn-1:0]  rr_q     [NumOut];
    logic [LogIn-1:0]  rr_d     [NumOut];
    logic [NumIn-1:0]  vld_d;
    logic [LogOut-1:0] idx_d    [NumIn];
    logic [NumIn-1:0]  vld_q    [MemLatency];
    logic [LogOut-1:0] idx_q    [MemLatency][NumIn];

    // Per slave port: route requests, pick the round-robin winner, forward its payload and grant
    always_comb begin
        for (int k = 0; k < NumOut; k++) begin
            for (int j = 0; j < NumIn; j++)
                port_req[k][j] = req_i[j] && (!NodeType || add_i[j*LogOut +: LogOut] == LogOut'(k));
            win[k] = arb_win(port_req[k], rr_q[k]);
            req_o[k] = |port_req[k];
            wdata_o[k*ReqDataWidth +: ReqDataWidth] = wdata_i[win[k]*ReqDataWidth +: ReqDataWidth];
            port_gnt[k] = (gnt_i[k] && req_o[k]) ? (NumIn'(1) << win[k]) : '0;
            rr_d[k] = (req_o[k] && gnt_i[k]) ? rr_q[k] + 1'b1 : rr_q[k];
        end
    end

    // Per master: collect the grant, remember which port served it, decide if a response is due
    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            gnt_o[j] = 1'b0;
            idx_d[j] = '0;
            if (NodeType) begin
                gnt_o[j] = port_gnt[add_i[j*LogOut +: LogOut]][j];
                idx_d[j] = add_i[j*LogOut +: LogOut];
            end else begin
                for (int k = NumOut - 1; k >= 0; k--) begin
                    if (port_gnt[k][j]) begin
                        gnt_o[j] = 1'b1;
                        idx_d[j] = LogOut'(k);
                    end
                end
            end
            vld_d[j] = req_i[j] && gnt_o[j] && (!wen_i[j] || WriteRespOn);
        end
    end

    // Arbiter priorities and the response delay line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumOut; k++) rr_q[k] <= '0;
            for (int s = 0; s < MemLatency; s++) begin
                vld_q[s] <= '0;
                for (int j = 0; j < NumIn; j++) idx_q[s][j] <= '0;
            end
        end else begin
            for (int k = 0; k < NumOut; k++) rr_q[k] <= rr_d[k];
            vld_q[0] <= vld_d;
            idx_q[0] <= idx_d;
            for (int s = 1; s < MemLatency; s++) begin
                vld_q[s] <= vld_q[s-1];
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    assign vld_o = vld_q[MemLatency-1];

    // Response data follows the stored port index, valid or not
    always_comb begin
        for (int j = 0; j < NumIn; j++)
            rdata_o[j*RespDataWidth +: RespDataWidth] = rdata_i[idx_q[MemLatency-1][j]*RespDataWidth +: RespDataWidth];
    end
endmodule

// File: tb/tb_tcdm_xbar_node.sv
// tb_tcdm_xbar_node: scoreboard bench over decode, write-response, latency and broadcast node variants
module tb_tcdm_xbar_node;
    typedef struct {
        int          inst;
        int          m;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [3:0]   req = '0, wen = '0, gnt_in = '0;
    logic [7:0]   add = '0;
    logic [127:0] wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic [127:0] rdata_in;
    logic [3:0]   gnt0, vld0, rq0, gnt1, vld1, rq1, gnt2, vld2, rq2;
    logic [127:0] wdo0, rdo0, wdo1, rdo1, wdo2, rdo2;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb [$];

    tcdm_xbar_node #(.WriteRespOn(0), .MemLatency(1), .NodeType(1)) u0 (
        .clk_i(clk), .rst_ni(rst0), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt0), .vld_o(vld0), .rdata_o(rdo0), .gnt_i(gnt_in), .req_o(rq0), .wdata_o(wdo0),
        .rdata_i(rdata_in));
    tcdm_xbar_node #(.WriteRespOn(1), .MemLatency(3), .NodeType(1)) u1 (
        .clk_i(clk), .rst_ni(rst1), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt1), .vld_o(vld1), .rdata_o(rdo1), .gnt_i(gnt_in), .req_o(rq1), .wdata_o(wdo1),
        .rdata_i(rdata_in));
    tcdm_xbar_node #(.WriteRespOn(1), .MemLatency(2), .NodeType(0)) u2 (
        .clk_i(clk), .rst_ni(rst2), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt2), .vld_o(vld2), .rdata_o(rdo2), .gnt_i(gnt_in), .req_o(rq2), .wdata_o(wdo2),
        .rdata_i(rdata_in));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_pat(input int c, input int k);
        logic [31:0] cc;
        logic [31:0] kk;
        cc = c;
        kk = k;
        return {cc[27:0], kk[3:0]};
    endfunction

    // Slave response data changes every cycle so a wrong latency or index shows up
    always_comb begin
        for (int k = 0; k < 4; k++) rdata_in[k*32 +: 32] = rd_pat(cyc, k);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int inst, input int m, input int port, input int lat);
        exp_t e;
        e.inst = inst;
        e.m    = m;
        e.cyc  = cyc + lat;
        e.data = rd_pat(cyc + lat, port);
        sb.push_back(e);
    endtask

    task automatic mon(input int inst, input logic [3:0] v, input logic [127:0] rd);
        int idx;
        for (int j = 0; j < 4; j++) begin
            if (v[j]) begin
                idx = -1;
                for (int q = 0; q < sb.size(); q++)
                    if (idx < 0 && sb[q].inst == inst && sb[q].m == j) idx = q;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL rsp u%0d m%0d: unexpected vld at cyc %0d data %h", inst, j, cyc, rd[j*32 +: 32]);
                end else begin
                    if (sb[idx].cyc != cyc || rd[j*32 +: 32] !== sb[idx].data) begin
                        errors++;
                        $display("FAIL rsp u%0d m%0d: got cyc %0d data %h want cyc %0d data %h",
                                 inst, j, cyc, rd[j*32 +: 32], sb[idx].cyc, sb[idx].data);
                    end
                    sb.delete(idx);
                end
            end
        end
    endtask

    // Monitor: every valid response is matched against the scoreboard
    always @(negedge clk) begin
        mon(0, vld0, rdo0);
        mon(1, vld1, rdo1);
        mon(2, vld2, rdo2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            req = '0;
            wen = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  exp_g [5];
        logic [31:0] pay;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        #2;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        idle(3);
        rst0 = 1'b1;
        @(negedge clk);
        chk("reset_vld0", vld0, 4'b0000);
        // decode: master 2 reads port 3
        tick();
        req = 4'b0100; add = 8'b0011_0000; wen = '0; gnt_in = 4'hF;
        @(negedge clk);
        chk("dec_req_o", rq0, 4'b1000);
        chk("dec_wdata_o", wdo0[127:96], 32'h33333333);
        chk("dec_gnt_o", gnt0, 4'b0100);
        push(0, 2, 3, 1);
        // contention: all masters on port 0
        for (int i = 0; i < 5; i++) begin
            tick();
            req = 4'hF; add = '0; gnt_in = 4'hF;
            @(negedge clk);
            pay = 32'h11111111 * ((i % 4) + 1);
            chk("cont_gnt", gnt0, exp_g[i]);
            chk("cont_wdata", wdo0[31:0], pay);
            push(0, i % 4, 0, 1);
        end
        // back-pressure: masters 1 and 3 on port 0, port 0 stalled
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 4'b1010; add = '0; gnt_in = 4'b1110;
            @(negedge clk);
            chk("bp_gnt", gnt0, 4'b0000);
            chk("bp_req_o", rq0, 4'b0001);
            chk("bp_wdata", wdo0[31:0], 32'h22222222);
        end
        tick();
        gnt_in = 4'hF;
        @(negedge clk);
        chk("bp_release_gnt", gnt0, 4'b0010);
        push(0, 1, 0, 1);
        tick();
        @(negedge clk);
        chk("bp_next_gnt", gnt0, 4'b1000);
        push(0, 3, 0, 1);
        // store with write responses off
        tick();
        req = 4'b0001; add = 8'b0000_0010; wen = 4'b0001;
        @(negedge clk);
        chk("wr_off_gnt", gnt0, 4'b0001);
        idle(1);
        @(negedge clk);
        chk("wr_off_vld", vld0, 4'b0000);
        idle(2);
        rst0 = 1'b0;
        rst1 = 1'b1;
        // write responses on, latency 3
        tick();
        req = 4'b0001; add = 8'b0000_0001; wen = 4'b0001; gnt_in = 4'hF;
        @(negedge clk);
        chk("wr_on_gnt", gnt1, 4'b0001);
        push(1, 0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 4'b0010; wen = '0;
            add = (i == 0) ? 8'b0000_1000 : (i == 1) ? 8'b0000_0000 : 8'b0000_1100;
            @(negedge clk);
            chk("lat3_gnt", gnt1, 4'b0010);
            push(1, 1, (i == 0) ? 2 : (i == 1) ? 0 : 3, 3);
        end
        idle(5);
        rst1 = 1'b0;
        rst2 = 1'b1;
        // broadcast: master 1, only port 2 grants
        tick();
        req = 4'b0010; add = '0; wen = '0; gnt_in = 4'b0100;
        @(negedge clk);
        chk("bc_req_o", rq2, 4'hF);
        chk("bc_wdata_o", wdo2, {4{32'h22222222}});
        chk("bc_gnt_o", gnt2, 4'b0010);
        push(2, 1, 2, 2);
        idle(4);
        // read then reset before its response
        tick();
        req = 4'b0001; gnt_in = 4'b0100;
        @(negedge clk);
        chk("rst_rd_gnt", gnt2, 4'b0001);
        tick();
        req = '0;
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_drop_vld", vld2, 4'b0000);
            tick();
        end
        rst2 = 1'b1;
        tick();
        req = 4'hF; gnt_in = 4'b0100;
        @(negedge clk);
        chk("rst_rr_gnt", gnt2, 4'b0001);
        chk("rst_rr_req_o", rq2, 4'hF);
        push(2, 0, 2, 2);
        idle(5);
        @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
